serial_adder_ctrl: RTL and testbench

- Bit-serial adder controller: sequences a single full-adder cell over WIDTH clock cycles, LSB first.
- The cell is one instance of the team's two-half-adder full adder (ports x, y, z, sum, carry).
- Holds operand shift registers, the carry flip-flop, a bit counter and a start/busy/done handshake.
- Area-optimised alternative to a ripple adder for slow-path arithmetic.

---
 rtl/serial_adder_ctrl.sv | 156 +++++++++++++++
 tb/tb_serial_adder_ctrl.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl - bit-serial adder controller.
//
// Sequences a single full-adder cell over WIDTH clock cycles, LSB first,
// producing {cout,sum} = a + b + cin (mod 2^(WIDTH+1)).
//
// Parameters:
//   WIDTH  operand/result width in bits (>= 2)
//   CNT_W  bit-counter width, derived from WIDTH
//
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   synchronous reset, active-low
//   start  in   request, accepted only in IDLE
//   sub    in   subtract select (only with SERIAL_ADDER_SUB_EN)
//   a, b   in   operands, sampled on the accepting edge
//   cin    in   carry-in, sampled on the accepting edge
//   busy   out  high while bits are being processed
//   done   out  one-cycle pulse, result valid
//   sum    out  result, held until the next result is written
//   cout   out  final carry-out (no-borrow flag when subtracting)
//
// Build option: define SERIAL_ADDER_SUB_EN to add the 'sub' input
// (a - b via a + ~b + 1).

module half_adder (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic carry
);
  assign sum   = a ^ b;
  assign carry = a & b;
endmodule

module full_adder (
  input  logic x,
  input  logic y,
  input  logic z,
  output logic sum,
  output logic carry
);
  logic w_s1;
  logic w_c1;
  logic w_c2;

  half_adder u_ha0 (.a(x),    .b(y), .sum(w_s1), .carry(w_c1));
  half_adder u_ha1 (.a(w_s1), .b(z), .sum(sum),  .carry(w_c2));

  assign carry = w_c1 | w_c2;
endmodule

module serial_adder_ctrl #(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  logic [1:0]       r_state;
  logic [WIDTH-1:0] r_opa;
  logic [WIDTH-1:0] r_opb;
  logic             r_carry;
  logic [CNT_W-1:0] r_cnt;
  // Holds the WIDTH-1 most recent cell sums; the final bit is merged in
  // combinationally so the visible result only changes once per operation.
  logic [WIDTH-2:0] r_sacc;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;

  logic [WIDTH-1:0] w_opb_ld;
  logic             w_cin_ld;
  logic             w_fa_s;
  logic             w_fa_c;
  logic [WIDTH-1:0] w_sacc_full;

`ifdef SERIAL_ADDER_SUB_EN
  assign w_opb_ld = sub ? ~b : b;
  assign w_cin_ld = sub ? 1'b1 : cin;
`else
  assign w_opb_ld = b;
  assign w_cin_ld = cin;
`endif

  full_adder u_fa (
    .x    (r_opa[0]),
    .y    (r_opb[0]),
    .z    (r_carry),
    .sum  (w_fa_s),
    .carry(w_fa_c)
  );

  assign w_sacc_full = {w_fa_s, r_sacc};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_opa   <= '0;
      r_opb   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_sacc  <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_opa   <= a;
            r_opb   <= w_opb_ld;
            r_carry <= w_cin_ld;
            r_cnt   <= '0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_opa   <= {1'b0, r_opa[WIDTH-1:1]};
          r_opb   <= {1'b0, r_opb[WIDTH-1:1]};
          r_carry <= w_fa_c;
          r_sacc  <= w_sacc_full[WIDTH-1:1];
          r_cnt   <= r_cnt + CNT_W'(1);
          if (r_cnt == LAST_BIT) begin
            r_sum   <= w_sacc_full;
            r_cout  <= w_fa_c;
            r_state <= S_DONE;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy = (r_state == S_RUN);
  assign done = (r_state == S_DONE);
  assign sum  = r_sum;
  assign cout = r_cout;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
module tb_serial_adder_ctrl;

  localparam int WIDTH = 8;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  int n_chk  = 0;
  int n_fail = 0;

  logic [WIDTH:0] exp_q[$];

  serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
`ifdef SERIAL_ADDER_SUB_EN
    .sub  (sub),
`endif
    .a    (a),
    .b    (b),
    .cin  (cin),
    .busy (busy),
    .done (done),
    .sum  (sum),
    .cout (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drive a request for one edge and record the reference result.
  task automatic launch(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                        input logic tcin, input logic tsub);
    logic [WIDTH:0] e;
    a = ta; b = tb; cin = tcin; sub = tsub; start = 1'b1;
    if (tsub) e = {1'b0, ta} + {1'b0, ~tb} + 9'd1;
    else      e = {1'b0, ta} + {1'b0, tb} + {8'd0, tcin};
    exp_q.push_back(e);
    tick();
    start = 1'b0;
    a = WIDTH'($urandom); b = WIDTH'($urandom); cin = 1'($urandom); sub = 1'($urandom);
  endtask

  // Wait (bounded) for done, optionally injecting an ignored start at RUN
  // cycle inj, then check timing and the scoreboard entry.
  task automatic finish_op(input string tag, input int inj, input logic [WIDTH-1:0] prev_sum);
    int cycles = 0;
    int nbusy = 0;
    bit overlap = 0;
    bit held = 1;
    logic [WIDTH:0] e;
    while (!done && cycles < 30) begin
      if (busy) nbusy++;
      if (sum !== prev_sum) held = 0;
      if (cycles == inj) begin
        start = 1'b1; a = 8'h01; b = 8'h01; cin = 1'b0; sub = 1'b0;
      end
      tick();
      start = 1'b0;
      if (busy && done) overlap = 1;
      cycles++;
    end
    chk({tag, "_done_seen"}, 32'(done), 32'd1);
    chk({tag, "_latency"}, 32'(cycles), 32'(WIDTH));
    chk({tag, "_busy_cycles"}, 32'(nbusy), 32'(WIDTH));
    chk({tag, "_no_overlap"}, 32'(overlap), 32'd0);
    chk({tag, "_sum_held"}, 32'(held), 32'd1);
    if (exp_q.size() == 0) begin
      chk({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd1);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_sum"}, 32'(sum), 32'(e[WIDTH-1:0]));
      chk({tag, "_cout"}, 32'(cout), 32'(e[WIDTH]));
    end
  endtask

  task automatic op(input string tag, input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                    input logic tcin, input logic tsub);
    logic [WIDTH-1:0] ps;
    ps = sum;
    launch(ta, tb, tcin, tsub);
    finish_op(tag, -1, ps);
    tick();
    chk({tag, "_done_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    logic [WIDTH-1:0] ps;
    bit any_done;
    rst_n = 1'b0; start = 1'b0; sub = 1'b0; a = '0; b = '0; cin = 1'b0;
    tick(); tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    rst_n = 1'b1;
    tick();

    op("basic", 8'h3C, 8'h5A, 1'b0, 1'b0);
    op("carry_ff01", 8'hFF, 8'h01, 1'b0, 1'b0);
    op("carry_ffff", 8'hFF, 8'hFF, 1'b1, 1'b0);

    // Start during RUN is ignored; start held through DONE is taken at the
    // first IDLE edge.
    ps = sum;
    launch(8'h55, 8'h22, 1'b1, 1'b0);
    finish_op("ignore_run", 3, ps);
    start = 1'b1; a = 8'h01; b = 8'h01; cin = 1'b0; sub = 1'b0;
    tick();
    chk("ignore_done_state", 32'(busy), 32'd0);
    chk("ignore_no_done", 32'(done), 32'd0);
    ps = sum;
    exp_q.push_back(9'h002);
    tick();
    start = 1'b0;
    chk("restart_accepted", 32'(busy), 32'd1);
    finish_op("restart", -1, ps);
    tick();

    // Reset in the middle of RUN discards the operation.
    launch(8'hA5, 8'h3C, 1'b0, 1'b0);
    tick(); tick(); tick(); tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    void'(exp_q.pop_front());
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_sum", 32'(sum), 32'd0);
    chk("midrst_cout", 32'(cout), 32'd0);
    any_done = 0;
    for (int i = 0; i < 12; i++) begin
      if (done || busy) any_done = 1;
      tick();
    end
    chk("midrst_idle", 32'(any_done), 32'd0);
    op("after_rst", 8'h7E, 8'h81, 1'b1, 1'b0);

    // Full-adder truth table through bit 0.
    for (int k = 0; k < 8; k++) begin
      logic [2:0] v;
      logic [1:0] fa;
      v = 3'(k);
      fa = 2'(v[2]) + 2'(v[1]) + 2'(v[0]);
      op("cell", {7'd0, v[2]}, {7'd0, v[1]}, v[0], 1'b0);
      chk("cell_bits", 32'(sum[1:0]), 32'(fa));
    end

    op("rand0", WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'b0);
    op("rand1", WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), 1'b0);

`ifdef SERIAL_ADDER_SUB_EN
    op("sub_nb", 8'h10, 8'h01, 1'b0, 1'b1);
    op("sub_borrow", 8'h01, 8'h02, 1'b1, 1'b1);
    op("sub_zero_sel", 8'h40, 8'h02, 1'b1, 1'b0);
`endif

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
